// File: rtl/alu_seq_core.sv
// Multi-cycle ALU core: single-cycle add/and/xor/sub/nop and a fixed-latency
// multiply behind a start/done handshake, all outputs registered.
module alu_seq_core #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MULT_LAT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 err
);

  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(MULT_LAT);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t            state_q, state_nxt;
  logic [CW-1:0]     cnt_q, cnt_nxt;
  logic [WIDTH-1:0]  a_q, a_nxt, b_q, b_nxt;
  logic [RW-1:0]     result_nxt;
  logic              done_nxt, err_nxt, busy_nxt;

  logic [WIDTH:0]    diff;
  logic [RW-1:0]     sum, sub_ext, product;

  // Subtract in WIDTH+1 bits so the borrow becomes the sign bit.
  assign diff    = {1'b0, A} - {1'b0, B};
  assign sub_ext = {{(WIDTH-1){diff[WIDTH]}}, diff};
  assign sum     = RW'(A) + RW'(B);
  assign product = RW'(a_q) * RW'(b_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      result  <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      a_q     <= a_nxt;
      b_q     <= b_nxt;
      result  <= result_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
      busy    <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    a_nxt      = a_q;
    b_nxt      = b_q;
    result_nxt = result;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    busy_nxt   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            a_nxt     = A;
            b_nxt     = B;
            cnt_nxt   = CW'(MULT_LAT - 1);
            busy_nxt  = 1'b1;
            state_nxt = S_MUL;
          end else begin
            done_nxt = 1'b1;
            case (op)
              OP_NOP:  result_nxt = result;
              OP_ADD:  result_nxt = sum;
              OP_AND:  result_nxt = RW'(A & B);
              OP_XOR:  result_nxt = RW'(A ^ B);
              OP_SUB:  result_nxt = sub_ext;
              default: begin
                result_nxt = '0;
                err_nxt    = 1'b1;
              end
            endcase
          end
        end
      end
      S_MUL: begin
        // Counter hits zero on the edge that publishes the product.
        if (cnt_q == CW'(1)) begin
          result_nxt = product;
          done_nxt   = 1'b1;
          cnt_nxt    = '0;
          state_nxt  = S_IDLE;
        end else begin
          cnt_nxt  = cnt_q - CW'(1);
          busy_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Scoreboard bench for alu_seq_core (WIDTH=8, MULT_LAT=3): stimulus pushes
// expected responses, a negedge monitor pops and compares on every done.
module tb_alu_seq_core;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned MULT_LAT = 3;
  localparam int unsigned RW       = 2 * WIDTH;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  logic             clk;
  logic             reset;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a_in, b_in;
  logic             busy, done, err;
  logic [RW-1:0]    result;

  alu_seq_core #(.WIDTH(WIDTH), .MULT_LAT(MULT_LAT)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .A      (a_in),
    .B      (b_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected done responses: {result, err}.
  logic [RW:0]   sb_q[$];
  // Direct signal checks sampled by stimulus: {actual, expected}.
  logic [2*RW-1:0] chk_q[$];
  string         chk_name_q[$];

  int  checks;
  int  errors;
  logic stim_done;

  task automatic expect_done(input logic [RW-1:0] res, input logic e);
    sb_q.push_back({res, e});
  endtask

  task automatic sample(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    chk_q.push_back({act, exp});
    chk_name_q.push_back(name);
  endtask

  task automatic cmd(input logic [2:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    start = 1'b1;
    op    = o;
    a_in  = a;
    b_in  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: sole owner of the check/error counters.
  initial begin
    logic [RW:0]     exp_e;
    logic [2*RW-1:0] c;
    string           nm;
    checks = 0;
    errors = 0;
    while (!stim_done) begin
      @(negedge clk);
      while (chk_q.size() > 0) begin
        c  = chk_q.pop_front();
        nm = chk_name_q.pop_front();
        checks++;
        if (c[2*RW-1:RW] !== c[RW-1:0]) begin
          errors++;
          $display("FAIL %s: got 0x%0h, want 0x%0h", nm, c[2*RW-1:RW], c[RW-1:0]);
        end
      end
      if (done === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got done=1 result=0x%0h err=%0b, want no done", result, err);
        end else begin
          exp_e = sb_q.pop_front();
          if (result !== exp_e[RW:1] || err !== exp_e[0]) begin
            errors++;
            $display("FAIL done_resp: got result=0x%0h err=%0b, want result=0x%0h err=%0b",
                     result, err, exp_e[RW:1], exp_e[0]);
          end
        end
      end else begin
        checks++;
        if (err !== 1'b0) begin
          errors++;
          $display("FAIL err_without_done: got err=%0b, want 0", err);
        end
      end
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL missing_done: got %0d outstanding responses, want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    stim_done = 1'b0;
    reset = 1'b1;
    start = 1'b0;
    op    = OP_NOP;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    sample("por_result", result, 16'h0000);
    sample("por_done", RW'(done), 16'h0000);
    sample("por_busy", RW'(busy), 16'h0000);
    reset = 1'b0;

    // ADD carry, then SUB with borrow.
    expect_done(16'h0100, 1'b0); cmd(OP_ADD, 8'hFF, 8'h01);
    expect_done(16'hFFFF, 1'b0); cmd(OP_SUB, 8'h01, 8'h02);
    idle(1);

    // Back-to-back single-cycle ops.
    expect_done(16'h0030, 1'b0); cmd(OP_AND, 8'hF0, 8'h3C);
    expect_done(16'h00CC, 1'b0); cmd(OP_XOR, 8'hF0, 8'h3C);
    expect_done(16'h00CC, 1'b0); cmd(OP_NOP, 8'h11, 8'h22);
    idle(1);

    // MUL with an ignored start and operand changes while busy.
    expect_done(16'hFE01, 1'b0); cmd(OP_MUL, 8'hFF, 8'hFF);
    sample("mul_busy_n1", RW'(busy), 16'h0001);
    cmd(OP_ADD, 8'h01, 8'h01);
    sample("mul_busy_n2", RW'(busy), 16'h0001);
    start = 1'b0; a_in = 8'h03; b_in = 8'h07;
    @(posedge clk); #1;
    sample("mul_busy_done", RW'(busy), 16'h0000);
    // Start in the done cycle is accepted.
    expect_done(16'h0004, 1'b0); cmd(OP_ADD, 8'h02, 8'h02);
    sample("single_busy", RW'(busy), 16'h0000);
    idle(1);

    // Illegal opcodes, then legal ops clear err.
    expect_done(16'h0000, 1'b1); cmd(3'b110, 8'h12, 8'h34);
    expect_done(16'h00FF, 1'b0); cmd(OP_ADD, 8'h80, 8'h7F);
    expect_done(16'h0000, 1'b1); cmd(3'b111, 8'hAA, 8'h55);
    expect_done(16'h0000, 1'b0); cmd(OP_NOP, 8'h00, 8'h00);
    expect_done(16'h00C8, 1'b0); cmd(OP_MUL, 8'h0A, 8'h14);
    idle(3);

    // Mid-cycle reset clears registered outputs without a clock edge.
    reset = 1'b1;
    #1;
    sample("rst_result", result, 16'h0000);
    sample("rst_done", RW'(done), 16'h0000);
    sample("rst_busy", RW'(busy), 16'h0000);
    sample("rst_err", RW'(err), 16'h0000);
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset during a multiply discards it.
    cmd(OP_MUL, 8'h03, 8'h04);
    idle(1);
    reset = 1'b1;
    #1;
    sample("mulrst_busy", RW'(busy), 16'h0000);
    sample("mulrst_result", result, 16'h0000);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(4);
    expect_done(16'h0005, 1'b0); cmd(OP_ADD, 8'h02, 8'h03);
    idle(3);
    stim_done = 1'b1;
  end

endmodule
